// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus: request/address from the fetch stage,
// ready/read-data back from instruction memory.
//   imem_req   : fetch request
//   imem_addr  : fetch byte address (ADDR_W bits)
//   imem_ready : memory has imem_rdata valid this cycle
//   imem_rdata : 32-bit instruction word
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch stage. Holds the PC, fetches a 32-bit word over the
// imem req/ready bus, latches it into the instruction register and presents it
// (plus the 11-bit opcode) to decode. On exec_done the PC advances to PC+4 or
// to PC + (branch_off << 2), modulo 2^ADDR_W.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   imem           : fetch_unit_if master (imem_req/addr out, ready/rdata in)
//   instr_o        : instruction register
//   opcode_o       : instr_o[31:21]
//   instr_valid_o  : instr_o holds an uncommitted instruction
//   exec_done_i    : commit the presented instruction
//   pc_src_i       : 1 = branch target, 0 = PC+4 (sampled with exec_done_i)
//   branch_off_i   : sign-extended word offset
//   pc_o           : address of the instruction in instr_o
// Optional macro FETCH_STATS_EN adds saturating counters stat_instr_o
// (commits) and stat_stall_o (REQ cycles without imem_ready).
module fetch_unit #(
  parameter int unsigned          ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_unit_if.master      imem,
  output logic [31:0]       instr_o,
  output logic [10:0]       opcode_o,
  output logic              instr_valid_o,
  input  logic              exec_done_i,
  input  logic              pc_src_i,
  input  logic [ADDR_W-1:0] branch_off_i,
`ifdef FETCH_STATS_EN
  output logic [31:0]       stat_instr_o,
  output logic [31:0]       stat_stall_o,
`endif
  output logic [ADDR_W-1:0] pc_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ISSUE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] off_sh;
  logic              commit;

  // Word offset to byte offset; the top two bits fall off the end.
  assign off_sh = branch_off_i << 2;
  assign commit = (state_q == ISSUE) && exec_done_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      IDLE:  state_d = REQ;
      REQ: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (exec_done_i) begin
          pc_d    = pc_src_i ? (pc_q + off_sh) : (pc_q + ADDR_W'(4));
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decodes of registered state
  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = pc_q;
  assign instr_o        = instr_q;
  assign opcode_o       = instr_q[31:21];
  assign instr_valid_o  = (state_q == ISSUE);
  assign pc_o           = pc_q;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_instr_q, stat_stall_q;
  logic        stall;

  assign stall = (state_q == REQ) && !imem.imem_ready;

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_instr_q <= 32'd0;
      stat_stall_q <= 32'd0;
    end else begin
      if (commit && (stat_instr_q != 32'hFFFF_FFFF))
        stat_instr_q <= stat_instr_q + 32'd1;
      if (stall && (stat_stall_q != 32'hFFFF_FFFF))
        stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_instr_o = stat_instr_q;
  assign stat_stall_o = stat_stall_q;
`else
  logic unused_commit;
  assign unused_commit = commit;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of one-cycle vectors walking the
// fetch/commit sequence, then hand sequences for wait states and
// reset asserted mid-operation.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [10:0] opcode;
  logic        instr_valid;
  logic        exec_done;
  logic        pc_src;
  logic [63:0] branch_off;
  logic [63:0] pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_instr;
  logic [31:0] stat_stall;
`endif

  int n_vec = 0;
  int n_err = 0;

  fetch_unit_if #(.ADDR_W(64)) bus ();

  fetch_unit #(.ADDR_W(64), .RESET_PC(64'd0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (bus.master),
    .instr_o       (instr),
    .opcode_o      (opcode),
    .instr_valid_o (instr_valid),
    .exec_done_i   (exec_done),
    .pc_src_i      (pc_src),
    .branch_off_i  (branch_off),
`ifdef FETCH_STATS_EN
    .stat_instr_o  (stat_instr),
    .stat_stall_o  (stat_stall),
`endif
    .pc_o          (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ed;
    logic        ps;
    logic [63:0] off;
    logic        rdy;
    logic [31:0] rd;
    logic [63:0] e_pc;
    logic [31:0] e_ins;
    logic        e_v;
    logic        e_req;
  } vec_t;

  vec_t tv [20];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ed, input logic ps, input logic [63:0] off,
                       input logic rdy, input logic [31:0] rd);
    exec_done           = ed;
    pc_src              = ps;
    branch_off          = off;
    bus.imem_ready      = rdy;
    bus.imem_rdata      = rd;
  endtask

  task automatic chk_state(input string tag, input logic [63:0] e_pc, input logic [31:0] e_ins,
                           input logic e_v, input logic e_req);
    logic [31:0] ei;
    ei = e_ins;
    chk({tag, " pc"},    pc,            e_pc);
    chk({tag, " addr"},  bus.imem_addr, e_pc);
    chk({tag, " instr"}, 64'(instr),    64'(ei));
    chk({tag, " op"},    64'(opcode),   64'(ei[31:21]));
    chk({tag, " valid"}, 64'(instr_valid), 64'(e_v));
    chk({tag, " req"},   64'(bus.imem_req), 64'(e_req));
  endtask

  initial begin
    //        ed ps off                    rdy rd            e_pc                   e_ins         v  req
    tv[0]  = '{0, 0, 64'd0,                 1, 32'h8B020020, 64'h0,                 32'h00000000, 0, 1};
    tv[1]  = '{0, 0, 64'd0,                 1, 32'h8B020020, 64'h0,                 32'h8B020020, 1, 0};
    tv[2]  = '{1, 0, 64'd0,                 0, 32'h00000000, 64'h4,                 32'h8B020020, 0, 1};
    tv[3]  = '{1, 1, 64'd5,                 0, 32'h00000000, 64'h4,                 32'h8B020020, 0, 1};
    tv[4]  = '{0, 0, 64'd0,                 1, 32'h91000421, 64'h4,                 32'h91000421, 1, 0};
    tv[5]  = '{0, 0, 64'd0,                 1, 32'hFFFFFFFF, 64'h4,                 32'h91000421, 1, 0};
    tv[6]  = '{1, 1, 64'h3F,                0, 32'h00000000, 64'h100,               32'h91000421, 0, 1};
    tv[7]  = '{0, 0, 64'd0,                 1, 32'hB4000060, 64'h100,               32'hB4000060, 1, 0};
    tv[8]  = '{1, 1, 64'd3,                 0, 32'h00000000, 64'h10C,               32'hB4000060, 0, 1};
    tv[9]  = '{0, 0, 64'd0,                 1, 32'hD503201F, 64'h10C,               32'hD503201F, 1, 0};
    tv[10] = '{1, 1, 64'hFFFFFFFFFFFFFFBF,  0, 32'h00000000, 64'h8,                 32'hD503201F, 0, 1};
    tv[11] = '{0, 0, 64'd0,                 1, 32'h17FFFFFD, 64'h8,                 32'h17FFFFFD, 1, 0};
    tv[12] = '{1, 1, 64'hFFFFFFFFFFFFFFFD,  0, 32'h00000000, 64'hFFFFFFFFFFFFFFFC,  32'h17FFFFFD, 0, 1};
    tv[13] = '{0, 0, 64'd0,                 1, 32'h8B020020, 64'hFFFFFFFFFFFFFFFC,  32'h8B020020, 1, 0};
    tv[14] = '{1, 0, 64'd7,                 0, 32'h00000000, 64'h0,                 32'h8B020020, 0, 1};
    tv[15] = '{0, 0, 64'd0,                 1, 32'h12345678, 64'h0,                 32'h12345678, 1, 0};
    tv[16] = '{1, 1, 64'hC000000000000001,  0, 32'h00000000, 64'h4,                 32'h12345678, 0, 1};
    tv[17] = '{1, 0, 64'd0,                 1, 32'hAAAA5555, 64'h4,                 32'hAAAA5555, 1, 0};
    tv[18] = '{1, 0, 64'd0,                 0, 32'h00000000, 64'h8,                 32'hAAAA5555, 0, 1};
    tv[19] = '{1, 0, 64'd0,                 0, 32'h00000000, 64'h8,                 32'hAAAA5555, 0, 1};

    rst_n = 1'b0;
    drive(0, 0, 64'd0, 0, 32'd0);
    #2;
    chk_state("reset", 64'h0, 32'h0, 0, 0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(tv[i].ed, tv[i].ps, tv[i].off, tv[i].rdy, tv[i].rd);
      tick();
      chk_state($sformatf("v%0d", i), tv[i].e_pc, tv[i].e_ins, tv[i].e_v, tv[i].e_req);
    end
    chk("add opcode", 64'(11'b10001011000), 64'(tv[1].e_ins[31:21]) & 64'h7FF);

    // Wait states: three not-ready REQ cycles, request held and address stable
    rst_n = 1'b0;
    drive(0, 0, 64'd0, 0, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_state("ws req", 64'h0, 32'h0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 64'd0, 0, 32'hDEADBEEF);
      tick();
      chk_state($sformatf("ws%0d", i), 64'h0, 32'h0, 0, 1);
    end
`ifdef FETCH_STATS_EN
    chk("stat_stall", 64'(stat_stall), 64'd3);
    chk("stat_instr0", 64'(stat_instr), 64'd0);
`endif
    drive(0, 0, 64'd0, 1, 32'hF8000020);
    tick();
    chk_state("ws done", 64'h0, 32'hF8000020, 1, 0);

    // Reach ISSUE at pc 0x40, then reset asynchronously with a commit pending
    drive(1, 1, 64'h10, 0, 32'd0);
    tick();
    chk_state("rm br", 64'h40, 32'hF8000020, 0, 1);
`ifdef FETCH_STATS_EN
    chk("stat_instr1", 64'(stat_instr), 64'd1);
`endif
    drive(0, 0, 64'd0, 1, 32'h8B1F03E0);
    tick();
    chk_state("rm issue", 64'h40, 32'h8B1F03E0, 1, 0);
    chk("rm opcode", 64'(opcode), 64'(11'b10001011000));
    drive(1, 1, 64'd4, 1, 32'h11111111);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("rm async", 64'h0, 32'h0, 0, 0);
    tick();
    chk_state("rm held", 64'h0, 32'h0, 0, 0);
`ifdef FETCH_STATS_EN
    chk("stat clr", 64'({stat_instr, stat_stall}), 64'd0);
`endif
    rst_n = 1'b1;
    drive(0, 0, 64'd0, 0, 32'd0);
    tick();
    chk_state("rm idle", 64'h0, 32'h0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
